// File: rtl/ittage_update_queue_if.sv
// ittage_update_queue_if
// Bundles the commit-side enqueue handshake and the predictor-side update
// port of the ITTAGE update queue.
//   enq_*      : resolved indirect-branch outcome offered by commit
//   enq_ready  : queue can accept this cycle
//   upd_stall  : predictor busy, hold issue
//   upd_*      : single-cycle update pulse towards the predictor
// Modports:
//   slave  : the queue's view (consumes enq_*, produces upd_*)
//   master : the environment's view (commit + predictor)
interface ittage_update_queue_if #(
    parameter int VADDR_W = 39,
    parameter int GHIST_W = 64,
    parameter int META_W  = 48
);
    logic               enq_valid;
    logic               enq_ready;
    logic               enq_tail_taken;
    logic               enq_indirect;
    logic [VADDR_W-1:0] enq_start_addr;
    logic [VADDR_W-1:0] enq_target;
    logic [VADDR_W-1:0] enq_pred_target;
    logic [GHIST_W-1:0] enq_ghist;
    logic [META_W-1:0]  enq_meta;

    logic               upd_stall;
    logic               upd_valid;
    logic [VADDR_W-1:0] upd_start_addr;
    logic [VADDR_W-1:0] upd_target;
    logic [GHIST_W-1:0] upd_ghist;
    logic [META_W-1:0]  upd_meta;

    modport slave (
        input  enq_valid, enq_tail_taken, enq_indirect,
        input  enq_start_addr, enq_target, enq_pred_target, enq_ghist, enq_meta,
        output enq_ready,
        input  upd_stall,
        output upd_valid, upd_start_addr, upd_target, upd_ghist, upd_meta
    );

    modport master (
        output enq_valid, enq_tail_taken, enq_indirect,
        output enq_start_addr, enq_target, enq_pred_target, enq_ghist, enq_meta,
        input  enq_ready,
        output upd_stall,
        input  upd_valid, upd_start_addr, upd_target, upd_ghist, upd_meta
    );
endinterface

// File: rtl/ittage_update_queue.sv
// ittage_update_queue
// Buffers resolved indirect-branch outcomes from commit, drops non-indirect
// or not-taken slots, coalesces a repeat of the newest queued entry, and
// issues entries to the ITTAGE predictor as single-cycle update pulses with
// a minimum idle gap between pulses.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : discard every queued entry (enqueue refused that cycle)
//   bus          : enqueue handshake + update port (slave modport)
//   mispred_cnt  : saturating count of accepted mispredicted targets
//   count        : current occupancy
module ittage_update_queue #(
    parameter int DEPTH   = 8,
    parameter int VADDR_W = 39,
    parameter int GHIST_W = 64,
    parameter int META_W  = 48,
    parameter int GAP     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    ittage_update_queue_if.slave     bus,
    output logic [15:0]              mispred_cnt,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef struct packed {
        logic [VADDR_W-1:0] start_addr;
        logic [VADDR_W-1:0] target;
        logic [GHIST_W-1:0] ghist;
        logic [META_W-1:0]  meta;
    } entry_t;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W-1:0]   count_r;
    logic [GAP_W-1:0]   gap_r;
    logic               upd_valid_r;
    entry_t             upd_entry_r;
    logic [15:0]        mispred_r;

    logic               empty_s;
    logic               full_s;
    logic               enq_ready_s;
    logic               keep_s;
    logic [IDX_W-1:0]   last_idx_s;
    logic               last_popped_s;
    logic               match_s;
    logic               coalesce_s;
    logic               write_s;
    logic               issue_s;
    logic               mispred_inc_s;
    logic [PTR_W-1:0]   count_nxt_s;
    entry_t             enq_entry_s;

    // Occupancy flags from the wrap-bit pointers and the enqueue ready.
    always_comb begin
        empty_s     = (head_r == tail_r);
        full_s      = (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]) &&
                      (head_r[IDX_W] != tail_r[IDX_W]);
        enq_ready_s = ~full_s & ~flush;
        issue_s     = ~empty_s & ~bus.upd_stall & (gap_r == {GAP_W{1'b0}}) & ~flush;
    end

    // Filter / coalesce decision for the incoming transfer.
    always_comb begin
        keep_s        = bus.enq_valid & enq_ready_s & bus.enq_tail_taken & bus.enq_indirect;
        last_idx_s    = tail_r[IDX_W-1:0] - IDX_W'(1);
        // The newest entry is the one leaving only when it is the sole entry.
        last_popped_s = issue_s && (head_r[IDX_W-1:0] == last_idx_s);
        match_s       = (mem_r[last_idx_s].start_addr == bus.enq_start_addr) &&
                        (mem_r[last_idx_s].target == bus.enq_target);
        coalesce_s    = keep_s & ~empty_s & ~last_popped_s & match_s;
        write_s       = keep_s & ~coalesce_s;
        mispred_inc_s = keep_s & (bus.enq_pred_target != bus.enq_target);
        enq_entry_s.start_addr = bus.enq_start_addr;
        enq_entry_s.target     = bus.enq_target;
        enq_entry_s.ghist      = bus.enq_ghist;
        enq_entry_s.meta       = bus.enq_meta;
    end

    // Next occupancy: enqueue and pop in the same cycle cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({write_s, issue_s})
            2'b10:   count_nxt_s = count_r + PTR_W'(1);
            2'b01:   count_nxt_s = count_r - PTR_W'(1);
            2'b11:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Head/tail pointers and occupancy register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {PTR_W{1'b0}};
        end else begin
            if (write_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (issue_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are meaningless outside [head, tail).
    always_ff @(posedge clk) begin
        if (!rst && write_s) begin
            mem_r[tail_r[IDX_W-1:0]] <= enq_entry_s;
        end
    end

    // Update pulse, issued data and rate-limit gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_r <= 1'b0;
            upd_entry_r <= '0;
            gap_r       <= {GAP_W{1'b0}};
        end else if (issue_s) begin
            upd_valid_r <= 1'b1;
            upd_entry_r <= mem_r[head_r[IDX_W-1:0]];
            gap_r       <= GAP_W'(GAP);
        end else begin
            upd_valid_r <= 1'b0;
            if (flush) begin
                gap_r <= {GAP_W{1'b0}};
            end else if (gap_r != {GAP_W{1'b0}}) begin
                gap_r <= gap_r - GAP_W'(1);
            end
        end
    end

    // Saturating mispredict counter; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_r <= 16'h0000;
        end else if (mispred_inc_s && (mispred_r != 16'hFFFF)) begin
            mispred_r <= mispred_r + 16'h0001;
        end
    end

    assign bus.enq_ready      = enq_ready_s;
    assign bus.upd_valid      = upd_valid_r;
    assign bus.upd_start_addr = upd_entry_r.start_addr;
    assign bus.upd_target     = upd_entry_r.target;
    assign bus.upd_ghist      = upd_entry_r.ghist;
    assign bus.upd_meta       = upd_entry_r.meta;
    assign mispred_cnt        = mispred_r;
    assign count              = count_r;
endmodule

// File: tb/tb_ittage_update_queue.sv
module tb_ittage_update_queue;
    localparam int VADDR_W = 39;
    localparam int GHIST_W = 64;
    localparam int META_W  = 48;

    typedef struct {
        logic [VADDR_W-1:0] s;
        logic [VADDR_W-1:0] t;
        logic [GHIST_W-1:0] g;
        logic [META_W-1:0]  m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] mispred_cnt;
    logic [3:0]  count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses   = 0;
    bit   prev_valid = 1'b0;
    exp_t exp_q[$];
    exp_t e_mon;

    ittage_update_queue_if #(.VADDR_W(VADDR_W), .GHIST_W(GHIST_W), .META_W(META_W)) bus ();

    ittage_update_queue #(
        .DEPTH(8), .VADDR_W(VADDR_W), .GHIST_W(GHIST_W), .META_W(META_W), .GAP(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .mispred_cnt (mispred_cnt),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.upd_valid) begin
                chk_eq("upd_gap", 64'(prev_valid), 64'd0);
                pulses++;
                if (exp_q.size() == 0) begin
                    chk_eq("upd_unexpected", 64'd1, 64'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk_eq("upd_start", 64'(bus.upd_start_addr), 64'(e_mon.s));
                    chk_eq("upd_target", 64'(bus.upd_target), 64'(e_mon.t));
                    chk_eq("upd_ghist", bus.upd_ghist, e_mon.g);
                    chk_eq("upd_meta", 64'(bus.upd_meta), 64'(e_mon.m));
                end
            end
            prev_valid = bus.upd_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic drive(input logic [VADDR_W-1:0] s, input logic [VADDR_W-1:0] t,
                         input logic [VADDR_W-1:0] p, input bit tk, input bit ind,
                         input logic [GHIST_W-1:0] g, input logic [META_W-1:0] m);
        bus.enq_valid       = 1'b1;
        bus.enq_tail_taken  = tk;
        bus.enq_indirect    = ind;
        bus.enq_start_addr  = s;
        bus.enq_target      = t;
        bus.enq_pred_target = p;
        bus.enq_ghist       = g;
        bus.enq_meta        = m;
    endtask

    // One transfer; called and returning at posedge+1.
    task automatic enq(input logic [VADDR_W-1:0] s, input logic [VADDR_W-1:0] t,
                       input logic [VADDR_W-1:0] p, input bit tk, input bit ind,
                       input logic [GHIST_W-1:0] g, input logic [META_W-1:0] m);
        int waitc = 0;
        drive(s, t, p, tk, ind, g, m);
        @(negedge clk);
        while (!bus.enq_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.enq_ready) chk_eq("enq_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.enq_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int waitc = 0;
        while ((exp_q.size() != 0 || count != 4'd0) && waitc < 100) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push_exp(input logic [VADDR_W-1:0] s, input logic [VADDR_W-1:0] t,
                            input logic [GHIST_W-1:0] g, input logic [META_W-1:0] m);
        exp_t x;
        x.s = s; x.t = t; x.g = g; x.m = m;
        exp_q.push_back(x);
    endtask

    initial begin
        bus.upd_stall = 1'b0;
        drive(39'h0, 39'h0, 39'h0, 1'b0, 1'b0, 64'h0, 48'h0);
        bus.enq_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
        chk_eq("rst_count", 64'(count), 64'd0);
        chk_eq("rst_mispred", 64'(mispred_cnt), 64'd0);
        chk_eq("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        chk_eq("rst_upd_target", 64'(bus.upd_target), 64'd0);
        @(posedge clk);
        #1;

        // Single transfer: pulse exactly two edges after acceptance.
        push_exp(39'h1000, 39'h2040, 64'hA5A5_0000_1111_2222, 48'h0000_0000_0001);
        enq(39'h1000, 39'h2040, 39'h2040, 1'b1, 1'b1, 64'hA5A5_0000_1111_2222, 48'h0000_0000_0001);
        @(negedge clk);
        chk_eq("lat_early", 64'(bus.upd_valid), 64'd0);
        @(negedge clk);
        chk_eq("lat_valid", 64'(bus.upd_valid), 64'd1);
        chk_eq("lat_target", 64'(bus.upd_target), 64'h2040);
        @(posedge clk);
        #1;
        wait_drain("t1_drain");
        chk_eq("t1_count", 64'(count), 64'd0);
        chk_eq("t1_mispred", 64'(mispred_cnt), 64'd0);

        // Fill under stall, then release and expect 8 alternate-cycle pulses.
        bus.upd_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [VADDR_W-1:0] s;
            logic [GHIST_W-1:0] g;
            s = 39'h8000 + 39'(i) * 39'h40;
            g = {32'($urandom), 32'($urandom)};
            push_exp(s, s + 39'h100, g, 48'(i + 16));
            enq(s, s + 39'h100, s + 39'h100, 1'b1, 1'b1, g, 48'(i + 16));
        end
        @(negedge clk);
        chk_eq("full_count", 64'(count), 64'd8);
        drive(39'hF000, 39'hF100, 39'hF100, 1'b1, 1'b1, 64'h9, 48'h9);
        @(negedge clk);
        chk_eq("full_ready", 64'(bus.enq_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.enq_valid = 1'b0;
        chk_eq("full_hold", 64'(count), 64'd8);
        pulses = 0;
        bus.upd_stall = 1'b0;
        wait_drain("t2_drain");
        chk_eq("t2_pulses", 64'(pulses), 64'd8);

        // Identical pair under stall coalesces into one entry.
        bus.upd_stall = 1'b1;
        pulses = 0;
        push_exp(39'h3000, 39'h4000, 64'h77, 48'h55);
        enq(39'h3000, 39'h4000, 39'h5000, 1'b1, 1'b1, 64'h77, 48'h55);
        enq(39'h3000, 39'h4000, 39'h5000, 1'b1, 1'b1, 64'h88, 48'h66);
        @(negedge clk);
        chk_eq("coal_count", 64'(count), 64'd1);
        chk_eq("coal_mispred", 64'(mispred_cnt), 64'd2);
        @(posedge clk);
        #1;
        bus.upd_stall = 1'b0;
        wait_drain("t3_drain");
        chk_eq("t3_pulses", 64'(pulses), 64'd1);

        // Non-indirect transfer is accepted and dropped.
        pulses = 0;
        drive(39'h6000, 39'h6100, 39'h6200, 1'b1, 1'b0, 64'h1, 48'h1);
        @(negedge clk);
        chk_eq("filt_ready", 64'(bus.enq_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.enq_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_eq("filt_count", 64'(count), 64'd0);
        chk_eq("filt_pulses", 64'(pulses), 64'd0);
        chk_eq("filt_mispred", 64'(mispred_cnt), 64'd2);

        // Flush with five queued entries and a concurrent offer.
        bus.upd_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq(39'hA000 + 39'(i) * 39'h10, 39'hB000, 39'hB000, 1'b1, 1'b1, 64'(i), 48'(i));
        end
        @(negedge clk);
        chk_eq("pre_flush_count", 64'(count), 64'd5);
        @(posedge clk);
        #1;
        flush = 1'b1;
        drive(39'hC000, 39'hC100, 39'hC100, 1'b1, 1'b1, 64'h2, 48'h2);
        @(negedge clk);
        chk_eq("flush_ready", 64'(bus.enq_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.enq_valid = 1'b0;
        bus.upd_stall = 1'b0;
        pulses = 0;
        chk_eq("flush_count", 64'(count), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk_eq("flush_pulses", 64'(pulses), 64'd0);
        chk_eq("flush_mispred", 64'(mispred_cnt), 64'd2);

        // Saturation: long run of coalesced mispredicting transfers.
        bus.upd_stall = 1'b1;
        push_exp(39'hD000, 39'hD100, 64'h3, 48'h3);
        drive(39'hD000, 39'hD100, 39'hD200, 1'b1, 1'b1, 64'h3, 48'h3);
        repeat (70000) @(posedge clk);
        #1;
        bus.enq_valid = 1'b0;
        chk_eq("sat_count", 64'(count), 64'd1);
        chk_eq("sat_mispred", 64'(mispred_cnt), 64'hFFFF);
        bus.upd_stall = 1'b0;
        wait_drain("t6_drain");

        // Reset mid-operation drops queued entries and clears the counter.
        bus.upd_stall = 1'b1;
        enq(39'hE000, 39'hE100, 39'hE100, 1'b1, 1'b1, 64'h4, 48'h4);
        enq(39'hE040, 39'hE140, 39'hE140, 1'b1, 1'b1, 64'h5, 48'h5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.upd_stall = 1'b0;
        pulses = 0;
        chk_eq("mrst_count", 64'(count), 64'd0);
        chk_eq("mrst_mispred", 64'(mispred_cnt), 64'd0);
        chk_eq("mrst_ready", 64'(bus.enq_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk_eq("mrst_pulses", 64'(pulses), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
